// File: rtl/pokey_keyscan_ctrl.sv
// POKEY keyboard scan sequencer: walks 64 key positions, debounces kr1_L, samples modifiers on kr2_L.
// Define POKEY_KEY_DEBOUNCE_EN for two-pass confirmation; undefined, keys accept on first sighting.
module pokey_keyscan_ctrl #(
    parameter int unsigned SCAN_DIV = 114
) (
    input  logic       o2,
    input  logic       rst,
    input  logic       scan_en,
    input  logic       kr1_L,
    input  logic       kr2_L,
    output logic [5:0] key_scan_L,
    output logic [7:0] kbcode,
    output logic       key_irq,
    output logic       brk_irq,
    output logic       key_down,
    output logic       shift_down
);

    localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);
    localparam logic [5:0] IDX_SHIFT = 6'h3F;
    localparam logic [5:0] IDX_CTRL  = 6'h3E;
    localparam logic [5:0] IDX_BREAK = 6'h30;

    typedef enum logic [1:0] {StIdle, StCand, StHeld} state_e;

    state_e     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [5:0] idx_q, idx_d;
    logic [5:0] k_q, k_d;
    logic [5:0] key_scan_q, key_scan_d;
    logic [7:0] kbcode_q, kbcode_d;
    logic       key_irq_q, key_irq_d;
    logic       brk_irq_q, brk_irq_d;
    logic       key_down_q, key_down_d;
    logic       shift_q, shift_d;
    logic       ctrl_q, ctrl_d;
    logic       brk_hist_q, brk_hist_d;
    logic       sample;
    logic       accept;

    assign sample = (div_q == DIV_LAST);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        idx_d      = idx_q;
        k_d        = k_q;
        key_scan_d = ~idx_q;
        kbcode_d   = kbcode_q;
        key_irq_d  = 1'b0;
        brk_irq_d  = 1'b0;
        key_down_d = key_down_q;
        shift_d    = shift_q;
        ctrl_d     = ctrl_q;
        brk_hist_d = brk_hist_q;
        accept     = 1'b0;

        if (!scan_en) begin
            // Scan halted: everything but the last code is forgotten.
            div_d      = 8'd0;
            idx_d      = 6'd0;
            state_d    = StIdle;
            key_down_d = 1'b0;
            shift_d    = 1'b0;
            ctrl_d     = 1'b0;
            brk_hist_d = 1'b0;
        end else if (sample) begin
            div_d = 8'd0;
            idx_d = idx_q + 6'd1;

            unique case (state_q)
                StIdle: begin
                    if (!kr1_L) begin
                        k_d = idx_q;
`ifdef POKEY_KEY_DEBOUNCE_EN
                        state_d = StCand;
`else
                        accept = 1'b1;
`endif
                    end
                end
`ifdef POKEY_KEY_DEBOUNCE_EN
                StCand: begin
                    if (idx_q == k_q) begin
                        if (!kr1_L) begin
                            accept = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
`endif
                StHeld: begin
                    if ((idx_q == k_q) && kr1_L) begin
                        state_d    = StIdle;
                        key_down_d = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase

            // Modifier registers feed kbcode with their pre-sample values.
            if (accept) begin
                state_d    = StHeld;
                kbcode_d   = {ctrl_q, shift_q, idx_q};
                key_irq_d  = 1'b1;
                key_down_d = 1'b1;
            end

            if (idx_q == IDX_SHIFT) begin
                shift_d = ~kr2_L;
            end
            if (idx_q == IDX_CTRL) begin
                ctrl_d = ~kr2_L;
            end
            if (idx_q == IDX_BREAK) begin
                brk_irq_d  = ~kr2_L & ~brk_hist_q;
                brk_hist_d = ~kr2_L;
            end
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge o2) begin
        if (rst) begin
            state_q    <= StIdle;
            div_q      <= 8'd0;
            idx_q      <= 6'd0;
            k_q        <= 6'd0;
            key_scan_q <= 6'h3F;
            kbcode_q   <= 8'h00;
            key_irq_q  <= 1'b0;
            brk_irq_q  <= 1'b0;
            key_down_q <= 1'b0;
            shift_q    <= 1'b0;
            ctrl_q     <= 1'b0;
            brk_hist_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            k_q        <= k_d;
            key_scan_q <= key_scan_d;
            kbcode_q   <= kbcode_d;
            key_irq_q  <= key_irq_d;
            brk_irq_q  <= brk_irq_d;
            key_down_q <= key_down_d;
            shift_q    <= shift_d;
            ctrl_q     <= ctrl_d;
            brk_hist_q <= brk_hist_d;
        end
    end

    assign key_scan_L = key_scan_q;
    assign kbcode     = kbcode_q;
    assign key_irq    = key_irq_q;
    assign brk_irq    = brk_irq_q;
    assign key_down   = key_down_q;
    assign shift_down = shift_q;

endmodule

// File: tb/tb_pokey_keyscan_ctrl.sv
// Bench for pokey_keyscan_ctrl: directed scenarios plus random key traffic against a cycle model.
module tb_pokey_keyscan_ctrl;

    localparam int DIV  = 4;
    localparam int PASS = 64 * DIV;
`ifdef POKEY_KEY_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif

    logic       o2 = 1'b0;
    logic       rst = 1'b1;
    logic       scan_en = 1'b0;
    logic       kr1_L = 1'b1;
    logic       kr2_L = 1'b1;
    logic [5:0] key_scan_L;
    logic [7:0] kbcode;
    logic       key_irq;
    logic       brk_irq;
    logic       key_down;
    logic       shift_down;

    pokey_keyscan_ctrl #(.SCAN_DIV(DIV)) dut (
        .o2         (o2),
        .rst        (rst),
        .scan_en    (scan_en),
        .kr1_L      (kr1_L),
        .kr2_L      (kr2_L),
        .key_scan_L (key_scan_L),
        .kbcode     (kbcode),
        .key_irq    (key_irq),
        .brk_irq    (brk_irq),
        .key_down   (key_down),
        .shift_down (shift_down)
    );

    always #5 o2 = ~o2;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Key matrix seen by the scanner: 1 = contact closed.
    bit press1 [64];
    bit press2 [64];

    // Reference model: time since scan start plus the key tracker in plain terms.
    int         m_t = 0;
    bit         m_cand = 0;
    bit         m_held = 0;
    int         m_k = 0;
    logic [7:0] m_kbcode = 8'h00;
    bit         m_keydown = 0;
    bit         m_shift = 0;
    bit         m_ctrl = 0;
    bit         m_brk_prev = 0;
    bit         m_kirq = 0;
    bit         m_birq = 0;
    logic [5:0] m_scan = 6'h3F;

    int cyc = 0;
    int n_kirq = 0;
    int n_birq = 0;
    int irq_cyc = -1;
    int track_key = -1;
    int sight_cyc = -1;

    function automatic int cur_idx();
        return (m_t / DIV) % 64;
    endfunction

    task automatic model_edge();
        int  idx;
        bit  smp;
        bit  low1;
        bit  low2;
        bit  acc;
        idx  = cur_idx();
        smp  = (m_t % DIV) == DIV - 1;
        low1 = (kr1_L == 1'b0);
        low2 = (kr2_L == 1'b0);
        acc  = 0;
        m_kirq = 0;
        m_birq = 0;
        if (rst) begin
            m_t = 0; m_cand = 0; m_held = 0; m_k = 0; m_kbcode = 8'h00;
            m_keydown = 0; m_shift = 0; m_ctrl = 0; m_brk_prev = 0; m_scan = 6'h3F;
        end else begin
            m_scan = ~idx[5:0];
            if (!scan_en) begin
                m_t = 0; m_cand = 0; m_held = 0;
                m_keydown = 0; m_shift = 0; m_ctrl = 0; m_brk_prev = 0;
            end else begin
                if (smp) begin
                    if (m_held) begin
                        if (idx == m_k && !low1) begin
                            m_held = 0;
                            m_keydown = 0;
                        end
                    end else if (m_cand) begin
                        if (idx == m_k) begin
                            m_cand = 0;
                            acc = low1;
                        end
                    end else if (low1) begin
                        m_k = idx;
                        if (DEB) m_cand = 1;
                        else acc = 1;
                    end
                    if (acc) begin
                        m_held = 1;
                        m_keydown = 1;
                        m_kirq = 1;
                        m_kbcode = {m_ctrl, m_shift, idx[5:0]};
                    end
                    if (idx == 63) m_shift = low2;
                    if (idx == 62) m_ctrl = low2;
                    if (idx == 48) begin
                        m_birq = low2 && !m_brk_prev;
                        m_brk_prev = low2;
                    end
                end
                m_t = (m_t + 1) % PASS;
            end
        end
    endtask

    task automatic step();
        int idx;
        idx = cur_idx();
        kr1_L = ~press1[idx];
        kr2_L = ~press2[idx];
        if (!rst && scan_en && idx == track_key && (m_t % DIV) == DIV - 1 && press1[idx]
            && sight_cyc < 0) begin
            sight_cyc = cyc;
        end
        @(posedge o2);
        model_edge();
        #1;
        check("key_scan_L", 32'(key_scan_L), 32'(m_scan));
        check("kbcode", 32'(kbcode), 32'(m_kbcode));
        check("key_irq", 32'(key_irq), 32'(m_kirq));
        check("brk_irq", 32'(brk_irq), 32'(m_birq));
        check("key_down", 32'(key_down), 32'(m_keydown));
        check("shift_down", 32'(shift_down), 32'(m_shift));
        if (key_irq === 1'b1) begin
            n_kirq++;
            irq_cyc = cyc + 1;
        end
        if (brk_irq === 1'b1) n_birq++;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_irq(input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = (key_irq === 1'b1);
        end
        check("irq_timeout", 32'(seen), 32'd1);
    endtask

    task automatic sync_pass();
        for (int i = 0; i < PASS + 4 && m_t != 0; i++) step();
    endtask

    task automatic clear_keys();
        for (int j = 0; j < 64; j++) begin
            press1[j] = 0;
            press2[j] = 0;
        end
    endtask

    initial begin
        int base_k;
        int base_b;
        int lat;
        clear_keys();

        // Reset state
        rst = 1; scan_en = 0;
        run(3);
        check("rst_scan", 32'(key_scan_L), 32'h3F);
        check("rst_kbcode", 32'(kbcode), 32'h00);
        check("rst_down", 32'({key_irq, brk_irq, key_down, shift_down}), 32'h0);

        // Scan walk, one full pass and a bit
        rst = 0; scan_en = 1;
        run(PASS + 8);
        check("walk_kbcode", 32'(kbcode), 32'h00);
        check("walk_irqs", 32'(n_kirq + n_birq), 32'd0);

        // Single key 0x15 with latency measurement
        track_key = 'h15; sight_cyc = -1; base_k = n_kirq;
        press1['h15] = 1;
        run_until_irq(3 * PASS);
        lat = irq_cyc - sight_cyc;
        check("k15_code", 32'(kbcode), 32'h15);
        check("k15_down", 32'(key_down), 32'd1);
        check("k15_lat_ok", 32'(lat >= (DEB ? 257 : 1) && lat <= (DEB ? 260 : 4)), 32'd1);
        press1['h15] = 0; track_key = -1;
        run(PASS);
        check("k15_release", 32'(key_down), 32'd0);
        check("k15_pulses", 32'(n_kirq - base_k), 32'd1);

        // One-pass glitch on key 0x16
        sync_pass();
        base_k = n_kirq;
        press1['h16] = 1;
        run(PASS);
        press1['h16] = 0;
        run(2 * PASS);
        check("glitch_pulses", 32'(n_kirq - base_k), DEB ? 32'd0 : 32'd1);
        check("glitch_code", 32'(kbcode), DEB ? 32'h15 : 32'h16);

        // Shift + ctrl + key 0x2A
        press2['h3F] = 1; press2['h3E] = 1;
        sync_pass();
        run(PASS);
        press1['h2A] = 1;
        run_until_irq(3 * PASS);
        check("mod_code", 32'(kbcode), 32'hEA);
        check("mod_shift", 32'(shift_down), 32'd1);
        clear_keys();
        run(2 * PASS);
        check("mod_shift_rel", 32'(shift_down), 32'd0);

        // Two keys together, lowest wins; second key ignored while held
        sync_pass();
        press1['h05] = 1; press1['h20] = 1;
        run_until_irq(3 * PASS);
        check("two_code", 32'(kbcode), 32'h05);
        press1['h20] = 0;
        run(PASS);
        base_k = n_kirq;
        press1['h20] = 1;
        run(2 * PASS);
        press1['h20] = 0;
        run(PASS);
        check("two_ignored", 32'(n_kirq - base_k), 32'd0);
        check("two_held", 32'(key_down), 32'd1);
        clear_keys();
        run(2 * PASS);

        // Break held for three passes
        sync_pass();
        base_b = n_birq;
        press2['h30] = 1;
        run(3 * PASS);
        press2['h30] = 0;
        run(PASS);
        check("brk_pulses", 32'(n_birq - base_b), 32'd1);

        // scan_en drop while a key is held
        press1['h08] = 1;
        run_until_irq(3 * PASS);
        run(50);
        scan_en = 0;
        step();
        check("halt_down", 32'(key_down), 32'd0);
        check("halt_code", 32'(kbcode), 32'h08);
        press1['h08] = 0;
        run(5);
        scan_en = 1;
        run(PASS);

        // Mid-pass reset
        run(37);
        rst = 1;
        step();
        check("midrst_scan", 32'(key_scan_L), 32'h3F);
        check("midrst_code", 32'(kbcode), 32'h00);
        rst = 0;
        run(PASS);

        // Random traffic against the model
        for (int it = 0; it < 40; it++) begin
            int r;
            clear_keys();
            for (int n = $urandom_range(0, 2); n > 0; n--) press1[$urandom_range(0, 63)] = 1;
            press2[63] = 1'($urandom_range(0, 1));
            press2[62] = 1'($urandom_range(0, 1));
            press2[48] = 1'($urandom_range(0, 1));
            run($urandom_range(1, 700));
            r = $urandom_range(0, 9);
            if (r == 0) begin
                scan_en = 0;
                run($urandom_range(1, 5));
                scan_en = 1;
            end else if (r == 1) begin
                rst = 1;
                step();
                rst = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
